squeeze_conv_lanes: RTL

Parametrised dual-path dot-product engine for the squeeze stage, and the successor to the fixed 8-lane squeeze convolution. Each accepted beat multiplies LANES signed activations by LANES signed kernel weights on a primary (3x3) path and, optionally, a secondary (1x1) path. The products are reduced through a pipelined adder tree, then shifted, saturated and optionally ReLU-clamped. PACK results are packed into one output word for the downstream bias/accumulate stage. It adds a partial-pack flush, a sticky overflow flag and ReLU support.

---
 rtl/squeeze_conv_lanes.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/squeeze_conv_lanes.sv
// Dual-path signed dot-product engine: products, pipelined adder tree, shift/saturate/ReLU,
// then a packer that gathers PACK results per output word with optional partial-pack flush.
module squeeze_conv_lanes #(
    parameter int LANES = 8,
    parameter int DW    = 12,
    parameter int KW    = 8,
    parameter int SHIFT = 7,
    parameter int PACK  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  add_1x1_en_i,
    input  logic                  relu_en_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [LANES*DW-1:0]   data_a_i,
    input  logic [LANES*KW-1:0]   ker_a_i,
    input  logic [LANES*DW-1:0]   data_b_i,
    input  logic [LANES*KW-1:0]   ker_b_i,
    input  logic                  flush_i,
    output logic [PACK*DW-1:0]    out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_busy_i,
    output logic                  ovf_o
);

    localparam int LG  = $clog2(LANES);
    localparam int SW  = DW + KW + LG + 1;
    localparam int NST = 4 + LG;
    localparam int CW  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    logic                  add_q, add_d, relu_q, relu_d;
    logic [NST-1:0]        vld_q, vld_d;
    logic [LANES*DW-1:0]   da_q, da_d, db_q, db_d;
    logic [LANES*KW-1:0]   ka_q, ka_d, kb_q, kb_d;
    logic signed [SW-1:0]  tree_a_q [LG+1][LANES];
    logic signed [SW-1:0]  tree_a_d [LG+1][LANES];
    logic signed [SW-1:0]  tree_b_q [LG+1][LANES];
    logic signed [SW-1:0]  tree_b_d [LG+1][LANES];
    logic signed [SW-1:0]  cmb_q, cmb_d;
    logic signed [SW-1:0]  shifted;
    logic [DW-1:0]         res_q, res_d;
    logic                  sat_q, sat_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PACK*DW-1:0]    pk_q, pk_d;
    logic                  pv_q, pv_d;
    logic                  ovf_q, ovf_d;
    logic                  fp_q, fp_d;
    logic                  acc, clear, pipe_empty, flush_exec;

    assign in_ready_o  = ~rst_i & ~start_i & ~fp_q & ~out_busy_i;
    assign acc         = in_valid_i & in_ready_o;
    assign clear       = rst_i | start_i;
    assign pipe_empty  = ~(|vld_q) & ~acc;
    assign flush_exec  = (flush_i | fp_q) & pipe_empty & ~clear;
    assign out_data_o  = pk_q;
    assign out_valid_o = pv_q;
    assign ovf_o       = ovf_q;

    always_comb begin
        add_d  = start_i ? add_1x1_en_i : add_q;
        relu_d = start_i ? relu_en_i : relu_q;
        vld_d  = clear ? '0 : {vld_q[NST-2:0], acc};
        da_d   = data_a_i;
        ka_d   = ker_a_i;
        db_d   = data_b_i;
        kb_d   = ker_b_i;
    end

    // Level 0 holds the full-precision products; each further level halves the live entries.
    always_comb begin
        tree_a_d = '{default: '0};
        tree_b_d = '{default: '0};
        for (int i = 0; i < LANES; i++) begin
            tree_a_d[0][i] = SW'($signed(da_q[(LANES-1-i)*DW +: DW])) *
                             SW'($signed(ka_q[(LANES-1-i)*KW +: KW]));
            tree_b_d[0][i] = SW'($signed(db_q[(LANES-1-i)*DW +: DW])) *
                             SW'($signed(kb_q[(LANES-1-i)*KW +: KW]));
        end
        for (int k = 1; k <= LG; k++) begin
            for (int i = 0; i < LANES / 2; i++) begin
                if (i < (LANES >> k)) begin
                    tree_a_d[k][i] = tree_a_q[k-1][2*i] + tree_a_q[k-1][2*i+1];
                    tree_b_d[k][i] = tree_b_q[k-1][2*i] + tree_b_q[k-1][2*i+1];
                end
            end
        end
        cmb_d = tree_a_q[LG][0] + (add_q ? tree_b_q[LG][0] : '0);
    end

    always_comb begin
        shifted = cmb_q >>> SHIFT;
        res_d   = shifted[DW-1:0];
        sat_d   = 1'b0;
        if (shifted > SAT_MAX) begin
            res_d = SAT_MAX[DW-1:0];
            sat_d = 1'b1;
        end else if (shifted < SAT_MIN) begin
            res_d = SAT_MIN[DW-1:0];
            sat_d = 1'b1;
        end
        if (relu_q && shifted[SW-1]) begin
            res_d = '0;
        end
    end

    // A flush only runs with the pipeline drained, so it never coincides with a landing result.
    always_comb begin
        pk_d  = pk_q;
        pv_d  = 1'b0;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        fp_d  = fp_q;
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
            fp_d  = 1'b0;
        end else begin
            if (vld_q[NST-1]) begin
                pk_d[(PACK-1-int'(cnt_q))*DW +: DW] = res_q;
                if (sat_q) begin
                    ovf_d = 1'b1;
                end
                if (cnt_q == CW'(PACK - 1)) begin
                    pv_d  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            if (flush_exec) begin
                if (cnt_q != '0) begin
                    for (int j = 0; j < PACK; j++) begin
                        if (j >= int'(cnt_q)) begin
                            pk_d[(PACK-1-j)*DW +: DW] = '0;
                        end
                    end
                    pv_d  = 1'b1;
                    cnt_d = '0;
                end
                fp_d = 1'b0;
            end else if (flush_i) begin
                fp_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            add_q  <= 1'b0;
            relu_q <= 1'b0;
            vld_q  <= '0;
            cnt_q  <= '0;
            pk_q   <= '0;
            pv_q   <= 1'b0;
            ovf_q  <= 1'b0;
            fp_q   <= 1'b0;
        end else begin
            add_q  <= add_d;
            relu_q <= relu_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            pk_q   <= pk_d;
            pv_q   <= pv_d;
            ovf_q  <= ovf_d;
            fp_q   <= fp_d;
        end
    end

    // Datapath registers need no reset: the valid chain decides what reaches the packer.
    always_ff @(posedge clk_i) begin
        da_q     <= da_d;
        ka_q     <= ka_d;
        db_q     <= db_d;
        kb_q     <= kb_d;
        tree_a_q <= tree_a_d;
        tree_b_q <= tree_b_d;
        cmb_q    <= cmb_d;
        res_q    <= res_d;
        sat_q    <= sat_d;
    end

endmodule
